fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
Read-side controller for the team's synchronous FIFO. It issues rd_en against the FIFO's empty flag and absorbs the FIFO's one-cycle registered read latency. It presents the data downstream as a valid/ready stream without bubbles. It sits between a synchronous FIFO instance and any stream consumer, such as a serializer or a packet engine.

Parameters:
DATA_WIDTH, 8, width of FIFO data and stream data
BUF_DEPTH, 2, entries in the internal skid buffer; minimum 2, power of two

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
flush  input  1  synchronous clear of buffer and in-flight read; FIFO contents untouched
fifo_empty  input  1  empty flag from FIFO
fifo_rd_en  output  1  read strobe to FIFO
fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid the cycle after an accepted read
out_valid  output  1  stream data valid
out_ready  input  1  downstream accept
out_data  output  DATA_WIDTH  stream data = buffer head
buf_level  output  $clog2(BUF_DEPTH)+1  entries currently held in the buffer

Behaviour:
- Reset (reset=1 at edge): rd_ptr=0, wr_ptr=0, occ=0, inflight=0. out_valid=0, out_data=0, buf_level=0. fifo_rd_en is 0 while reset=1.
- pop = out_valid && out_ready. Handshake is transferred on an edge where pop=1.
- fifo_rd_en (combinational) = !reset && !flush && !fifo_empty && (occ + inflight - pop) < BUF_DEPTH.
  - The path from out_ready to fifo_rd_en is combinational, by design. It gives full throughput.
- inflight is a register. It is set to 1 on any edge where fifo_rd_en=1, and cleared to 0 otherwise.
- Capture: on an edge where inflight=1, fifo_rd_data is written to buf[wr_ptr] and wr_ptr increments modulo BUF_DEPTH.
- out_valid = (occ != 0). out_data = buf[rd_ptr], registered storage only. out_data = 0 when occ=0 after reset.
- On pop, rd_ptr increments modulo BUF_DEPTH.
- occ next-state:
  - +1 on capture only
  - -1 on pop only
  - unchanged on both or neither
- buf_level = occ.
- Invariant: occ + inflight <= BUF_DEPTH at all times. The buffer never overflows. The bench asserts this.
- Latency: FIFO non-empty with the buffer idle gives fifo_rd_en in the same cycle. out_valid rises 2 edges later: the FIFO registers the data, then the buffer captures it.
- Steady state, with FIFO never empty and out_ready=1: one word per cycle, no bubbles.
- out_valid stays high and out_data stays stable while out_ready=0. Stream rules apply: no retraction.
- flush=1 at an edge:
  - occ, pointers and inflight all go to 0.
  - A read returning in that cycle is discarded. The word is lost from the FIFO, which is intended.
  - fifo_rd_en=0 during flush.
- reset mid-transfer behaves as flush, plus out_data goes to 0.
- fifo_empty is trusted. No read is issued when fifo_empty=1, so the FIFO's underflow guard is never relied upon.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_WIDTH default constant
  - the function clog2 for level widths
  - the typedef for data words, shared with the synchronous FIFO
- One natural sub-module: stream_skid_buf, the BUF_DEPTH storage plus pointers, occ and the push/pop interface.
- fifo_stream_reader instantiates stream_skid_buf and contains only the issue/inflight logic.

Test Plan:
1. Reset then idle with fifo_empty=1 -> fifo_rd_en=0, out_valid=0, out_data=0, buf_level=0 for 10 cycles.
2. FIFO preloaded with 0x11,0x22,0x33,0x44 and out_ready=1 -> fifo_rd_en high for 4 consecutive cycles. out_valid rises 2 cycles after the first read. Data 0x11..0x44 appears on 4 consecutive cycles with no bubble.
3. FIFO holds 6 words and out_ready=0 -> exactly 2 reads issued, buf_level=2, out_data=first word held stable. Releasing out_ready -> remaining 4 words drain in order.
4. out_ready toggling 1,0,1,0 with a continuous FIFO source (data 0x00..0x0F) -> all 16 words received in order, no duplicates or drops, occ+inflight<=2 every cycle.
5. flush asserted on the cycle after a read issue (in flight 0xA5), with the buffer holding 0x5A -> next cycle out_valid=0, buf_level=0. 0xA5 and 0x5A never appear. The next FIFO word is delivered normally.
6. reset asserted mid-stream with buf_level=2 -> next cycle all outputs at reset values. Deassert -> the reader resumes from the current FIFO head.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO family and its read-side
// stream adapter.
//   DATA_WIDTH_DEF : default word width used by the FIFO and its readers
//   data_t         : default-width data word type shared with the FIFO
//   clog2()        : ceiling log2, used to size pointers and level counters
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

    // Smallest r such that 2**r >= value; a level counter that must hold
    // the value itself needs clog2(value)+1 bits.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader_if
// Bundles the FIFO read port and the downstream valid/ready stream seen by
// fifo_stream_reader.
//   fifo_empty   : FIFO empty flag            (environment -> reader)
//   fifo_rd_en   : FIFO read strobe           (reader -> environment)
//   fifo_rd_data : FIFO data, one cycle after an accepted read
//   out_valid    : stream data valid          (reader -> consumer)
//   out_ready    : consumer accept            (consumer -> reader)
//   out_data     : stream data, head of the skid buffer
//   buf_level    : entries currently held in the skid buffer
// master modport is taken by the reader, slave by whatever surrounds it.
// ---------------------------------------------------------------------------
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = 2
);

    localparam int LEVEL_W = clog2(BUF_DEPTH) + 1;

    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [LEVEL_W-1:0]    buf_level;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data,
        output buf_level
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data,
        input  buf_level
    );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// ---------------------------------------------------------------------------
// stream_skid_buf
// Small circular buffer that holds words returned by the FIFO until the
// stream consumer accepts them.
//   clk         : clock, rising edge
//   reset       : synchronous active-high; clears pointers, level and storage
//   flush       : synchronous clear of pointers and level; a push in the same
//                 cycle is dropped, storage contents are left as they are
//   push_i      : write push_data_i at the tail this cycle
//   push_data_i : word to write
//   pop_i       : consumer took the head this cycle
//   valid_o     : buffer holds at least one word
//   head_o      : word at the read pointer (registered storage only)
//   level_o     : number of words held
// The caller guarantees a push never lands on a full buffer.
// ---------------------------------------------------------------------------
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           push_i,
    input  logic [DATA_WIDTH-1:0]          push_data_i,
    input  logic                           pop_i,
    output logic                           valid_o,
    output logic [DATA_WIDTH-1:0]          head_o,
    output logic [clog2(BUF_DEPTH):0]      level_o
);

    localparam int PTR_W   = clog2(BUF_DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_d;
    logic [LEVEL_W-1:0]    occ_q;
    logic [LEVEL_W-1:0]    occ_d;
    logic                  pop_ok;

    assign pop_ok = pop_i && (occ_q != '0);

    // Next-state for the pointers and the level. Pointers wrap for free
    // because BUF_DEPTH is a power of two. A simultaneous push and pop
    // leaves the level unchanged.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_ok})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // State update. Reset also zeroes the storage so the head reads 0 until
    // the first word arrives; flush only rewinds, and any push in that cycle
    // is discarded along with everything already held.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign valid_o = (occ_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
// Read-side controller for the synchronous FIFO. Issues reads against the
// empty flag, absorbs the FIFO's one-cycle read latency and presents the
// words as a bubble-free valid/ready stream.
//   clk   : clock, rising edge
//   reset : synchronous active-high
//   flush : synchronous clear of buffer and in-flight read
//   bus   : fifo_stream_reader_if.master (FIFO read port + output stream)
// ---------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    fifo_stream_reader_if.master  bus
);

    localparam int LEVEL_W = clog2(BUF_DEPTH) + 1;
    localparam int SUM_W   = LEVEL_W + 1;

    logic                  inflight_q;
    logic                  inflight_d;
    logic                  pop;
    logic                  rd_en;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [LEVEL_W-1:0]    buf_level;
    logic [SUM_W-1:0]      demand;

    assign pop = buf_valid && bus.out_ready;

    // A read may issue only if the word it returns is guaranteed a slot:
    // count what is held plus what is already on its way, less the word
    // leaving this cycle. Using pop here (a combinational path from
    // out_ready) is what lets the reader sustain one word per cycle.
    always_comb begin
        demand     = SUM_W'(buf_level) + SUM_W'(inflight_q) - SUM_W'(pop);
        rd_en      = !reset && !flush && !bus.fifo_empty
                     && (demand < SUM_W'(BUF_DEPTH));
        inflight_d = rd_en;
    end

    // Tracks the read whose data appears on fifo_rd_data next cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .push_i      (inflight_q),
        .push_data_i (bus.fifo_rd_data),
        .pop_i       (pop),
        .valid_o     (buf_valid),
        .head_o      (buf_head),
        .level_o     (buf_level)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = buf_valid;
    assign bus.out_data   = buf_head;
    assign bus.buf_level  = buf_level;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
// Directed bench for fifo_stream_reader. A behavioural synchronous FIFO with
// one-cycle registered read data feeds the reader; a negedge monitor records
// every accepted stream word and every issued read.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int DATA_WIDTH = 8;
    localparam int BUF_DEPTH  = 2;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    int assertCount = 0;
    int failCount   = 0;

    data_t      fifoMem [256];
    logic [7:0] fifoHead = 8'd0;
    logic [7:0] fifoTail = 8'd0;
    logic       inflightModel = 1'b0;

    data_t rxMem [256];
    int    rxCount = 0;
    int    rxBase  = 0;
    int    rdCount = 0;
    int    rdBase  = 0;

    fifo_stream_reader_if #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) bus ();

    fifo_stream_reader #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Behavioural FIFO: empty when head meets tail, data registered one
    // cycle after the read strobe.
    assign bus.fifo_empty = (fifoHead == fifoTail);

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rd_data <= fifoMem[fifoHead];
            fifoHead         <= fifoHead + 8'd1;
        end
        inflightModel <= bus.fifo_rd_en;
    end

    // Mid-cycle monitor: the buffer must never be over-committed, reads must
    // never hit an empty FIFO, and every handshake is logged for later
    // comparison.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("occ_plus_inflight_le_depth",
                        32'((32'(bus.buf_level) + 32'(inflightModel)) <= BUF_DEPTH), 32'd1);
            if (bus.fifo_rd_en) begin
                checkOutput("read_while_empty", 32'(bus.fifo_empty), 32'd0);
                rdCount = rdCount + 1;
            end
            if (bus.out_valid && bus.out_ready && !flush && rxCount < 256) begin
                rxMem[rxCount] = bus.out_data;
                rxCount = rxCount + 1;
            end
        end
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount = assertCount + 1;
        if (observed !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic fl, input logic rst);
        bus.out_ready = rdy;
        flush         = fl;
        reset         = rst;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleCycle();
        @(negedge clk);
    endtask

    task automatic pushWord(input data_t w);
        fifoMem[fifoTail] = w;
        fifoTail = fifoTail + 8'd1;
    endtask

    task automatic waitRx(input int count, input int budget);
        int cycles;
        cycles = 0;
        while ((rxCount - rxBase) < count && cycles < budget) begin
            nextCycle();
            cycles = cycles + 1;
        end
    endtask

    logic expRd [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic expV  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    data_t expD [7] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Idle after reset with an empty FIFO.
        for (int i = 0; i < 10; i++) begin
            sampleCycle();
            checkOutput("idle_rd_en",     32'(bus.fifo_rd_en), 32'd0);
            checkOutput("idle_out_valid", 32'(bus.out_valid),  32'd0);
            checkOutput("idle_out_data",  32'(bus.out_data),   32'd0);
            checkOutput("idle_buf_level", 32'(bus.buf_level),  32'd0);
            nextCycle();
        end

        // Four preloaded words streamed with a ready consumer.
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushWord(8'h11);
        pushWord(8'h22);
        pushWord(8'h33);
        pushWord(8'h44);
        for (int c = 0; c < 7; c++) begin
            sampleCycle();
            checkOutput("stream_rd_en",     32'(bus.fifo_rd_en), 32'(expRd[c]));
            checkOutput("stream_out_valid", 32'(bus.out_valid),  32'(expV[c]));
            if (expV[c] || c < 2) begin
                checkOutput("stream_out_data", 32'(bus.out_data), 32'(expD[c]));
            end
            nextCycle();
        end

        // Six words with a stalled consumer: only two reads may issue.
        applyStimulus(1'b0, 1'b0, 1'b0);
        rdBase = rdCount;
        for (int i = 0; i < 6; i++) begin
            pushWord(data_t'(8'h61 + i));
        end
        repeat (6) nextCycle();
        for (int i = 0; i < 2; i++) begin
            sampleCycle();
            checkOutput("stall_reads",     32'(rdCount - rdBase), 32'd2);
            checkOutput("stall_buf_level", 32'(bus.buf_level),    32'd2);
            checkOutput("stall_out_valid", 32'(bus.out_valid),    32'd1);
            checkOutput("stall_out_data",  32'(bus.out_data),     32'h61);
            nextCycle();
        end
        rxBase = rxCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitRx(6, 50);
        checkOutput("stall_drain_count", 32'(rxCount - rxBase), 32'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput("stall_drain_word", 32'(rxMem[rxBase + i]), 32'(8'h61 + i));
        end

        // Sixteen words with out_ready toggling every cycle.
        rxBase = rxCount;
        for (int i = 0; i < 16; i++) begin
            pushWord(data_t'(i));
        end
        begin
            int cycles;
            cycles = 0;
            while ((rxCount - rxBase) < 16 && cycles < 200) begin
                nextCycle();
                bus.out_ready = ~bus.out_ready;
                cycles = cycles + 1;
            end
        end
        bus.out_ready = 1'b1;
        repeat (5) nextCycle();
        checkOutput("toggle_count", 32'(rxCount - rxBase), 32'd16);
        for (int i = 0; i < 16; i++) begin
            checkOutput("toggle_word", 32'(rxMem[rxBase + i]), 32'(i));
        end

        // Flush with 0x5A buffered and 0xA5 in flight; 0x77 must follow.
        applyStimulus(1'b0, 1'b0, 1'b0);
        pushWord(8'h5A);
        nextCycle();
        nextCycle();
        pushWord(8'hA5);
        pushWord(8'h77);
        sampleCycle();
        checkOutput("flush_pre_level", 32'(bus.buf_level),  32'd1);
        checkOutput("flush_pre_data",  32'(bus.out_data),   32'h5A);
        checkOutput("flush_pre_rd_en", 32'(bus.fifo_rd_en), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        sampleCycle();
        checkOutput("flush_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        sampleCycle();
        checkOutput("flush_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_buf_level", 32'(bus.buf_level), 32'd0);
        rxBase = rxCount;
        bus.out_ready = 1'b1;
        waitRx(1, 20);
        repeat (5) nextCycle();
        checkOutput("flush_rx_count", 32'(rxCount - rxBase), 32'd1);
        checkOutput("flush_rx_word",  32'(rxMem[rxBase]),    32'h77);

        // Reset mid-stream with a full buffer; resume from the FIFO head.
        applyStimulus(1'b0, 1'b0, 1'b0);
        pushWord(8'h81);
        pushWord(8'h82);
        pushWord(8'h83);
        pushWord(8'h84);
        repeat (4) nextCycle();
        sampleCycle();
        checkOutput("rst_pre_level", 32'(bus.buf_level), 32'd2);
        checkOutput("rst_pre_data",  32'(bus.out_data),  32'h81);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1);
        sampleCycle();
        checkOutput("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        sampleCycle();
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_buf_level", 32'(bus.buf_level), 32'd0);
        checkOutput("rst_out_data",  32'(bus.out_data),  32'd0);
        rxBase = rxCount;
        bus.out_ready = 1'b1;
        waitRx(2, 20);
        repeat (5) nextCycle();
        checkOutput("rst_rx_count", 32'(rxCount - rxBase), 32'd2);
        checkOutput("rst_rx_word0", 32'(rxMem[rxBase]),     32'h83);
        checkOutput("rst_rx_word1", 32'(rxMem[rxBase + 1]), 32'h84);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
